// File: rtl/noc_router_output_port_if.sv
// Bundle of the crossbar write channel, the downstream link and the
// status outputs of one NoC router output port.
//
// Handshake rules (both channels): a beat moves at a rising clk edge where
// valid and ready are both high. The sender holds valid and its data stable
// until that edge. The receiver's ready has no meaning while valid is low.
interface noc_router_output_port_if #(
   parameter int PKT_W = 13
);
   logic             wr_valid;
   logic [PKT_W-1:0] wr_packet;
   logic             wr_ready;
   logic             valid_out;
   logic [PKT_W-1:0] packet_out;
   logic             ready_in;
   logic [1:0]       route_out;
   logic             stall_timeout;
   logic [7:0]       tx_count;

   // Crossbar/downstream side: drives the packet and the downstream ready.
   modport master (
      output wr_valid,
      output wr_packet,
      output ready_in,
      input  wr_ready,
      input  valid_out,
      input  packet_out,
      input  route_out,
      input  stall_timeout,
      input  tx_count
   );

   // Output port side.
   modport slave (
      input  wr_valid,
      input  wr_packet,
      input  ready_in,
      output wr_ready,
      output valid_out,
      output packet_out,
      output route_out,
      output stall_timeout,
      output tx_count
   );
endinterface

// File: rtl/noc_router_output_port.sv
// NoC router output port: a small FIFO fed by the crossbar and an output
// register that drives the downstream link. It holds each packet until it
// is accepted, flags long downstream stalls and counts delivered packets.
module noc_router_output_port #(
   parameter int PKT_W   = 13,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   noc_router_output_port_if.slave  port,
   output logic [1:0]               state_dbg
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int STALL_W = $clog2(TIMEOUT) + 1;

   localparam logic [CNT_W-1:0]   FIFO_FULL_CNT = CNT_W'(DEPTH);
   localparam logic [STALL_W-1:0] STALL_LAST    = STALL_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   // FIFO storage and bookkeeping
   logic [PKT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;

   // Output register and control state
   state_t             state;
   logic               valid_q;
   logic [PKT_W-1:0]   packet_q;
   logic [STALL_W-1:0] stall_cnt;
   logic               stall_q;
   logic [7:0]         tx_cnt;

   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic xfer;
   logic load;

   // Full FIFO refuses writes even if the head leaves this cycle.
   assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
   assign fifo_empty = (fifo_cnt == '0);
   assign push       = port.wr_valid && !fifo_full;
   assign xfer       = valid_q && port.ready_in;
   // The head moves into the output register whenever it is free or being freed.
   assign load       = !fifo_empty && (!valid_q || xfer);

   assign port.wr_ready      = !fifo_full;
   assign port.valid_out     = valid_q;
   assign port.packet_out    = packet_q;
   assign port.route_out     = packet_q[PKT_W-1 -: 2];
   assign port.stall_timeout = stall_q;
   assign port.tx_count      = tx_cnt;
   assign state_dbg          = state;

   // FIFO payload storage; written only on an accepted crossbar beat.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= port.wr_packet;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (load) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, load})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Link FSM: output register, stall counter and timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         valid_q   <= 1'b0;
         packet_q  <= '0;
         stall_cnt <= '0;
         stall_q   <= 1'b0;
      end else begin
         if (load) begin
            packet_q <= mem[rd_ptr];
            valid_q  <= 1'b1;
         end else if (xfer) begin
            valid_q  <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               stall_cnt <= '0;
               if (load) begin
                  state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  stall_cnt <= '0;
                  if (!load) begin
                     state <= ST_IDLE;
                  end
               end else if (stall_cnt == STALL_LAST) begin
                  // This edge is the TIMEOUT-th consecutive stalled edge.
                  state   <= ST_STALL;
                  stall_q <= 1'b1;
               end else begin
                  stall_cnt <= stall_cnt + STALL_W'(1);
               end
            end
            ST_STALL: begin
               if (xfer) begin
                  stall_q   <= 1'b0;
                  stall_cnt <= '0;
                  state     <= load ? ST_SEND : ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               stall_cnt <= '0;
               stall_q   <= 1'b0;
            end
         endcase
      end
   end

   // Delivered-packet counter, wraps 255 -> 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_cnt <= '0;
      end else if (xfer) begin
         tx_cnt <= tx_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_noc_router_output_port.sv
// Bench for noc_router_output_port: directed scenarios followed by random
// traffic, every cycle compared against a queue-based behavioural model.
module tb_noc_router_output_port;

   localparam int PKT_W   = 13;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   // Clock / reset
   logic clk = 1'b0;
   logic reset;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   noc_router_output_port_if #(.PKT_W(PKT_W)) bus ();

   noc_router_output_port #(
      .PKT_W(PKT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .port(bus),
      .state_dbg(state_dbg)
   );

   // Scoreboard / reference model state
   logic [PKT_W-1:0] exp_q[$];   // packets waiting behind the output register
   logic             m_valid;
   logic [PKT_W-1:0] m_pkt;
   int               m_stall;    // consecutive stalled edges since last transfer
   logic             m_to;
   logic [7:0]       m_tx;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance the model by one rising edge with the given inputs.
   task automatic model_edge(input logic wv, input logic [PKT_W-1:0] pkt,
                             input logic rdy, input logic rst);
      logic xfer;
      logic accept;
      if (rst) begin
         exp_q.delete();
         m_valid = 1'b0;
         m_pkt   = '0;
         m_stall = 0;
         m_to    = 1'b0;
         m_tx    = 8'd0;
      end else begin
         xfer   = m_valid && rdy;
         accept = wv && (exp_q.size() < DEPTH);
         if (xfer) begin
            m_tx    = m_tx + 8'd1;
            m_stall = 0;
            m_to    = 1'b0;
         end else if (m_valid) begin
            m_stall++;
            if (m_stall >= TIMEOUT) m_to = 1'b1;
         end
         if ((!m_valid || xfer) && exp_q.size() > 0) begin
            m_pkt   = exp_q.pop_front();
            m_valid = 1'b1;
         end else if (xfer) begin
            m_valid = 1'b0;
         end
         if (accept) exp_q.push_back(pkt);
      end
   endtask

   task automatic compare_all();
      check("valid_out", 32'(bus.valid_out), 32'(m_valid));
      check("packet_out", 32'(bus.packet_out), 32'(m_pkt));
      check("route_out", 32'(bus.route_out), 32'(m_pkt[PKT_W-1 -: 2]));
      check("wr_ready", 32'(bus.wr_ready), 32'(exp_q.size() < DEPTH));
      check("stall_timeout", 32'(bus.stall_timeout), 32'(m_to));
      check("tx_count", 32'(bus.tx_count), 32'(m_tx));
   endtask

   // Driver: apply inputs, take one edge, update model, compare #1 later.
   task automatic step(input logic wv, input logic [PKT_W-1:0] pkt,
                       input logic rdy, input logic rst);
      reset         = rst;
      bus.wr_valid  = wv;
      bus.wr_packet = pkt;
      bus.ready_in  = rdy;
      @(posedge clk);
      model_edge(wv, pkt, rdy, rst);
      #1;
      compare_all();
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      int mode;
      logic [PKT_W-1:0] p;
      reset         = 1'b1;
      bus.wr_valid  = 1'b0;
      bus.wr_packet = '0;
      bus.ready_in  = 1'b0;

      // Reset state
      do_reset(2);
      step(1'b0, '0, 1'b0, 1'b0);
      check("rst_valid", 32'(bus.valid_out), 32'd0);
      check("rst_packet", 32'(bus.packet_out), 32'd0);
      check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
      check("rst_tx", 32'(bus.tx_count), 32'd0);
      check("rst_timeout", 32'(bus.stall_timeout), 32'd0);

      // Single packet: write at edge N, visible after N+1, transfer at N+2
      step(1'b1, 13'h1A5A, 1'b1, 1'b0);
      check("single_not_yet", 32'(bus.valid_out), 32'd0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("single_valid", 32'(bus.valid_out), 32'd1);
      check("single_pkt", 32'(bus.packet_out), 32'h1A5A);
      check("single_route", 32'(bus.route_out), 32'd3);
      step(1'b0, '0, 1'b1, 1'b0);
      check("single_tx", 32'(bus.tx_count), 32'd1);
      check("single_done", 32'(bus.valid_out), 32'd0);

      // Back-to-back with ready held high
      do_reset(1);
      for (int i = 1; i <= 4; i++) step(1'b1, PKT_W'(i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("b2b_tx", 32'(bus.tx_count), 32'd4);

      // Backpressure fill: capacity DEPTH+1
      do_reset(1);
      for (int i = 0; i < 6; i++) step(1'b1, PKT_W'(13'h100 + i), 1'b0, 1'b0);
      check("bp_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("bp_head", 32'(bus.packet_out), 32'h100);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("bp_tx", 32'(bus.tx_count), 32'd5);

      // Timeout after exactly TIMEOUT stalled edges
      do_reset(1);
      step(1'b1, 13'h0ABC, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);           // load edge, first stalled edge is next
      for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, '0, 1'b0, 1'b0);
      check("to_early", 32'(bus.stall_timeout), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("to_set", 32'(bus.stall_timeout), 32'd1);
      check("to_hold_pkt", 32'(bus.packet_out), 32'h0ABC);
      step(1'b0, '0, 1'b1, 1'b0);
      check("to_clear", 32'(bus.stall_timeout), 32'd0);
      check("to_tx", 32'(bus.tx_count), 32'd1);

      // Reset mid-transfer discards everything
      do_reset(1);
      for (int i = 0; i < 4; i++) step(1'b1, PKT_W'(13'h0200 + i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("mid_rst_valid", 32'(bus.valid_out), 32'd0);
      check("mid_rst_tx", 32'(bus.tx_count), 32'd0);

      // 256 transfers wrap tx_count to 0
      for (int i = 0; i < 256; i++) step(1'b1, PKT_W'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("wrap_tx", 32'(bus.tx_count), 32'd0);

      // Random traffic in phases of mixed, blocked and free-running downstream
      mode = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i % 40 == 0) mode = $urandom_range(0, 2);
         p = PKT_W'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            step(1'b0, '0, 1'b1, 1'b1);
         end else begin
            step($urandom_range(0, 99) < 60, p,
                 (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 99) < 60),
                 1'b0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_router_output_port.md
Name: noc_router_output_port

Overview:
Transmit-side port of the NoC router, at the opposite end of the input-port link. It accepts routed 13-bit packets from the router crossbar into a small FIFO. It drives them to the downstream router input port over a valid/ready link, holding each packet stable until the downstream port accepts it. It also detects downstream stalls with a timeout and counts delivered packets.

Parameters:
PKT_W, 13, packet width; bits [PKT_W-1:PKT_W-2] are the destination address, the remainder is payload.
DEPTH, 4, FIFO entries (power of two, ≥2).
TIMEOUT, 16, consecutive stalled cycles before the timeout is flagged (≥2).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
wr_valid  input  1  crossbar presents a packet.
wr_packet  input  PKT_W  packet from crossbar.
wr_ready  output  1  port can accept; combinational, equals !fifo_full.
valid_out  output  1  packet_out valid toward downstream input port; registered.
packet_out  output  PKT_W  packet toward downstream; registered.
ready_in  input  1  downstream input port accepts.
route_out  output  2  packet_out[PKT_W-1:PKT_W-2]; combinational.
stall_timeout  output  1  downstream stalled ≥ TIMEOUT cycles; registered.
tx_count  output  8  packets delivered, modulo 256.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset), sampled only on the rising clk edge.
- Reset values: valid_out=0, packet_out=0, stall_timeout=0, tx_count=0, FIFO empty (wr_ready=1), stall counter=0, FSM=IDLE.
- Write: accepted at the edge where wr_valid && wr_ready. When the FIFO is full, wr_ready=0 even if a pop occurs in the same cycle; no bypass of a full FIFO.
- Transfer: occurs at the edge where valid_out && ready_in.
  - While valid_out=1 and no transfer has occurred, packet_out must not change.
  - ready_in is ignored while valid_out=0.
- Output register load: at an edge where the FIFO is non-empty and (valid_out=0 or a transfer occurs), the FIFO head pops into packet_out and valid_out=1.
  - Otherwise, when a transfer occurs, valid_out goes to 0.
- Simultaneous write and pop in one cycle are both legal. The FIFO count is unchanged.
- Latency and throughput:
  - Write at edge N into an empty port gives valid_out=1 after edge N+1.
  - With ready_in held high, one packet transfers per cycle.
- Total capacity is DEPTH+1 packets (FIFO plus output register). Head and tail pointers wrap modulo DEPTH.
- FSM:
  - IDLE (valid_out=0): goes to SEND when a packet loads.
  - SEND (valid_out=1):
    - On transfer with no reload, goes to IDLE.
    - If ready_in=0, the stall counter increments.
    - When the counter reaches TIMEOUT-1 with ready_in=0, goes to STALL and sets stall_timeout=1 at that edge. stall_timeout is therefore high after TIMEOUT stalled edges.
  - STALL (valid_out=1, stall_timeout=1): on transfer, clears stall_timeout and the counter, then goes to SEND if reloaded, else IDLE.
  - The stall counter clears on every transfer.
- tx_count increments by 1 per transfer and wraps 255→0.
- Reset mid-operation: the FIFO contents and the in-flight packet are discarded. valid_out drops at the reset edge regardless of ready_in, and no transfer is counted at that edge.

Test Plan:
- Reset: assert reset 2 cycles, then wr_valid=0 → valid_out=0, packet_out=0, wr_ready=1, tx_count=0, stall_timeout=0.
- Single packet: write 13'h1A5A at edge N with ready_in=1 → valid_out=1, packet_out=13'h1A5A, route_out=2'b11 after edge N+1; transfer at N+2; tx_count=1; valid_out=0.
- Back-to-back: write 13'h0001..13'h0004 on consecutive edges with ready_in=1 → four consecutive transfer cycles in order; tx_count=4; no bubbles.
- Backpressure fill:
  - ready_in=0, write 6 packets → wr_ready falls after the 5th accept and the 6th is held off; packet_out stays at the first packet.
  - Then ready_in=1 → 5 packets delivered in order.
- Timeout: hold one packet with ready_in=0 → stall_timeout=1 exactly after the 16th stalled edge, packet_out unchanged; ready_in=1 for 1 cycle → stall_timeout=0, tx_count+1.
- Reset mid-transfer and wrap:
  - Reset with 3 packets queued and valid_out=1 → all cleared, nothing further emitted.
  - Separately, 256 transfers → tx_count returns to 0.
